cmd_master_sequencer: RTL and testbench

//  Sequences one SD command transaction over the command physical layer (cmd_phys).

---
 rtl/cmd_master_sequencer_if.sv | 32 +++
 rtl/cmd_master_sequencer.sv | 137 +++++++++++++
 tb/tb_cmd_master_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_master_sequencer_if.sv
// Command physical-layer link between the command master sequencer and cmd_phys.
// The master drives the request/acknowledge strobes and the outgoing frame;
// the slave (cmd_phys) returns its acknowledge, response strobe and response.
interface cmd_master_sequencer_if;
    logic        strobe_to_phys;
    logic        ack_to_phys;
    logic        idle_to_phys;
    logic [39:0] cmd_to_send;
    logic        ack_from_phys;
    logic        strobe_from_phys;
    logic [39:0] response_in;

    modport master (
        output strobe_to_phys,
        output ack_to_phys,
        output idle_to_phys,
        output cmd_to_send,
        input  ack_from_phys,
        input  strobe_from_phys,
        input  response_in
    );

    modport slave (
        input  strobe_to_phys,
        input  ack_to_phys,
        input  idle_to_phys,
        input  cmd_to_send,
        output ack_from_phys,
        output strobe_from_phys,
        output response_in
    );
endinterface

// File: rtl/cmd_master_sequencer.sv
// SD command master sequencer: builds the 40-bit command frame, hands it to
// cmd_phys with a strobe/ack handshake, optionally waits for the response
// under a saturating timeout, and reports response plus status to the host.
module cmd_master_sequencer #(
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_DEF = TIMEOUT_W'(64)
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 new_cmd,
    input  logic [5:0]           cmd_index,
    input  logic [31:0]          cmd_argument,
    input  logic                 expect_resp,
    input  logic [TIMEOUT_W-1:0] timeout_value,
    output logic                 busy,
    output logic                 cmd_complete,
    output logic                 timeout_error,
    output logic                 index_error,
    output logic [39:0]          response_out,
    cmd_master_sequencer_if.master phy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK_LOW,
        WAIT_RESP,
        ACK_RESP,
        DONE
    } state_t;

    state_t               state;
    logic [TIMEOUT_W-1:0] timer;
    logic [TIMEOUT_W-1:0] limit;
    logic [5:0]           index_q;
    logic                 expect_q;

    // Transaction FSM; every output is a register updated alongside the state.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; there is no memory array, so every register
    // gets an async reset value.
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            timer              <= '0;
            limit              <= TIMEOUT_DEF;
            index_q            <= '0;
            expect_q           <= 1'b0;
            busy               <= 1'b0;
            cmd_complete       <= 1'b0;
            timeout_error      <= 1'b0;
            index_error        <= 1'b0;
            response_out       <= '0;
            phy.strobe_to_phys <= 1'b0;
            phy.ack_to_phys    <= 1'b0;
            phy.idle_to_phys   <= 1'b1;
            phy.cmd_to_send    <= '0;
        end else begin
            // Completion is a single-cycle pulse unless re-armed below.
            cmd_complete <= 1'b0;

            case (state)
                IDLE: begin
                    phy.idle_to_phys <= 1'b1;
                    if (new_cmd) begin
                        phy.cmd_to_send    <= {1'b0, 1'b1, cmd_index, cmd_argument};
                        index_q            <= cmd_index;
                        expect_q           <= expect_resp;
                        limit              <= (timeout_value == '0) ? TIMEOUT_DEF : timeout_value;
                        timeout_error      <= 1'b0;
                        index_error        <= 1'b0;
                        busy               <= 1'b1;
                        phy.strobe_to_phys <= 1'b1;
                        phy.idle_to_phys   <= 1'b0;
                        state              <= SEND;
                    end
                end

                SEND: begin
                    if (phy.ack_from_phys) begin
                        phy.strobe_to_phys <= 1'b0;
                        state              <= WAIT_ACK_LOW;
                    end
                end

                WAIT_ACK_LOW: begin
                    if (!phy.ack_from_phys) begin
                        if (expect_q) begin
                            timer <= '0;
                            state <= WAIT_RESP;
                        end else begin
                            cmd_complete     <= 1'b1;
                            phy.idle_to_phys <= 1'b1;
                            state            <= DONE;
                        end
                    end
                end

                WAIT_RESP: begin
                    // Saturate rather than wrap so a huge limit can never alias.
                    if (timer != '1)
                        timer <= timer + TIMEOUT_W'(1);
                    // A response arriving on the expiry cycle is still accepted.
                    if (phy.strobe_from_phys) begin
                        response_out    <= phy.response_in;
                        index_error     <= (phy.response_in[37:32] != index_q);
                        phy.ack_to_phys <= 1'b1;
                        state           <= ACK_RESP;
                    end else if (timer == limit - TIMEOUT_W'(1)) begin
                        timeout_error    <= 1'b1;
                        cmd_complete     <= 1'b1;
                        phy.idle_to_phys <= 1'b1;
                        state            <= DONE;
                    end
                end

                ACK_RESP: begin
                    if (!phy.strobe_from_phys) begin
                        phy.ack_to_phys  <= 1'b0;
                        cmd_complete     <= 1'b1;
                        phy.idle_to_phys <= 1'b1;
                        state            <= DONE;
                    end
                end

                DONE: begin
                    busy             <= 1'b0;
                    phy.idle_to_phys <= 1'b1;
                    state            <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_master_sequencer.sv
// Directed bench for cmd_master_sequencer: the stimulus process plays host and
// cmd_phys, pushing the expected outcome of each transaction into a queue;
// a monitor pops and compares whenever the DUT pulses cmd_complete.
module tb_cmd_master_sequencer;

    logic        sd_clock = 1'b0;
    logic        reset = 1'b1;
    logic        new_cmd = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_argument = '0;
    logic        expect_resp = 1'b0;
    logic [15:0] timeout_value = '0;
    logic        busy;
    logic        cmd_complete;
    logic        timeout_error;
    logic        index_error;
    logic [39:0] response_out;

    cmd_master_sequencer_if bus ();

    cmd_master_sequencer #(
        .TIMEOUT_W  (16),
        .TIMEOUT_DEF(16'd64)
    ) dut (
        .sd_clock     (sd_clock),
        .reset        (reset),
        .new_cmd      (new_cmd),
        .cmd_index    (cmd_index),
        .cmd_argument (cmd_argument),
        .expect_resp  (expect_resp),
        .timeout_value(timeout_value),
        .busy         (busy),
        .cmd_complete (cmd_complete),
        .timeout_error(timeout_error),
        .index_error  (index_error),
        .response_out (response_out),
        .phy          (bus)
    );

    always #5 sd_clock = ~sd_clock;

    typedef struct {
        logic [39:0] frame;
        logic [39:0] resp;
        logic        to;
        logic        ie;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [39:0] R2 = 40'h08000001AA;
    localparam logic [39:0] R3 = 40'h09000001AA;
    localparam logic [39:0] R6 = 40'h01CAFEF00D;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic push(input logic [39:0] frame, input logic [39:0] resp, input logic to, input logic ie);
        exp_t e;
        e.frame = frame;
        e.resp  = resp;
        e.to    = to;
        e.ie    = ie;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic er,
                         input logic [15:0] tmo, input logic hold);
        cmd_index     = idx;
        cmd_argument  = arg;
        expect_resp   = er;
        timeout_value = tmo;
        new_cmd       = 1'b1;
        tick();
        if (!hold)
            new_cmd = 1'b0;
        check("accept_strobe", bus.strobe_to_phys, 1);
        check("accept_busy", busy, 1);
    endtask

    // cmd_phys acknowledges after 'delay' cycles and holds ack for two cycles.
    task automatic phys_ack(input int delay);
        repeat (delay) tick();
        check("strobe_hold", bus.strobe_to_phys, 1);
        bus.ack_from_phys = 1'b1;
        tick();
        check("strobe_drop", bus.strobe_to_phys, 0);
        tick();
        bus.ack_from_phys = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge sd_clock);
            if (!reset && cmd_complete) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_complete: got cmd_complete=1 expected no completion");
                end else begin
                    e = sb.pop_front();
                    check("sb_frame", cmd_to_send_w(), e.frame);
                    check("sb_response", response_out, e.resp);
                    check("sb_timeout_err", timeout_error, e.to);
                    check("sb_index_err", index_error, e.ie);
                end
            end
        end
    end

    function automatic logic [39:0] cmd_to_send_w();
        return bus.cmd_to_send;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.ack_from_phys    = 1'b0;
        bus.strobe_from_phys = 1'b0;
        bus.response_in      = '0;

        // Reset state
        tick();
        tick();
        check("reset_flags", {busy, cmd_complete, timeout_error, index_error,
                              bus.strobe_to_phys, bus.ack_to_phys, bus.idle_to_phys}, 7'b0000001);
        check("reset_response", response_out, 0);
        check("reset_frame", bus.cmd_to_send, 0);
        reset = 1'b0;
        tick();

        // T1: no response expected
        push(40'h4000000000, 40'h0, 1'b0, 1'b0);
        issue(6'd0, 32'h0, 1'b0, 16'd0, 1'b0);
        phys_ack(2);
        wait_idle("t1_idle");

        // T2: good response
        push(40'h48000001AA, R2, 1'b0, 1'b0);
        issue(6'd8, 32'h1AA, 1'b1, 16'd0, 1'b0);
        phys_ack(1);
        repeat (3) tick();
        bus.strobe_from_phys = 1'b1;
        bus.response_in      = R2;
        tick();
        check("t2_ack_rise", bus.ack_to_phys, 1);
        repeat (2) tick();
        check("t2_ack_hold", bus.ack_to_phys, 1);
        bus.strobe_from_phys = 1'b0;
        tick();
        check("t2_ack_release", bus.ack_to_phys, 0);
        wait_idle("t2_idle");

        // T3: response carries the wrong index
        push(40'h48000001AA, R3, 1'b0, 1'b1);
        issue(6'd8, 32'h1AA, 1'b1, 16'd0, 1'b0);
        phys_ack(1);
        tick();
        bus.strobe_from_phys = 1'b1;
        bus.response_in      = R3;
        tick();
        bus.strobe_from_phys = 1'b0;
        tick();
        wait_idle("t3_idle");
        check("t3_ie_held", index_error, 1);

        // T4: timeout after 10 cycles in WAIT_RESP
        push(40'h45DEADBEEF, R3, 1'b1, 1'b0);
        issue(6'd5, 32'hDEADBEEF, 1'b1, 16'd10, 1'b0);
        check("t4_ie_cleared", index_error, 0);
        phys_ack(1);
        n = 0;
        while (!timeout_error && n < 40) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", n, 10);
        wait_idle("t4_idle");
        check("t4_idle_to_phys", bus.idle_to_phys, 1);

        // T5: reset during WAIT_RESP aborts with no completion
        issue(6'd2, 32'h12345678, 1'b1, 16'd0, 1'b0);
        phys_ack(0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("t5_reset_flags", {busy, cmd_complete, timeout_error, index_error,
                                 bus.strobe_to_phys, bus.ack_to_phys, bus.idle_to_phys}, 7'b0000001);
        check("t5_reset_response", response_out, 0);
        check("t5_reset_frame", bus.cmd_to_send, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // T6: new_cmd while busy is ignored; strobe on the expiry cycle wins
        push(40'h4111111111, R6, 1'b0, 1'b0);
        issue(6'd1, 32'h11111111, 1'b1, 16'd4, 1'b0);
        new_cmd   = 1'b1;
        cmd_index = 6'd3;
        tick();
        new_cmd = 1'b0;
        check("t6_busy_ignore_frame", bus.cmd_to_send, 40'h4111111111);
        phys_ack(0);
        repeat (3) tick();
        bus.strobe_from_phys = 1'b1;
        bus.response_in      = R6;
        tick();
        check("t6_no_timeout", timeout_error, 0);
        check("t6_ack_rise", bus.ack_to_phys, 1);
        bus.strobe_from_phys = 1'b0;
        tick();
        wait_idle("t6_idle");

        // T7: new_cmd held high re-triggers right after returning to IDLE
        push(40'h7FFFFFFFFF, R6, 1'b0, 1'b0);
        push(40'h7FFFFFFFFF, R6, 1'b0, 1'b0);
        issue(6'd63, 32'hFFFFFFFF, 1'b0, 16'd0, 1'b1);
        phys_ack(1);
        tick();
        check("t7_gap_busy", busy, 0);
        tick();
        check("t7_retrigger_busy", busy, 1);
        check("t7_retrigger_strobe", bus.strobe_to_phys, 1);
        new_cmd = 1'b0;
        phys_ack(1);
        wait_idle("t7_idle");

        repeat (3) tick();
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
